// File: rtl/mem_access_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_access_pkg
// Brief   : Shared bus widths, ALU op encodings and MEM-stage FSM states.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

  localparam int ALU_OP_W    = 8;
  localparam int DATA_ADDR_W = 32;
  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int MEM_SEL_W   = 4;

  localparam logic [ALU_OP_W-1:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store(input logic [ALU_OP_W-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_align.sv
//------------------------------------------------------------------------------
// Module  : mem_access_align
// Brief   : Big-endian byte-lane steering, store replication, load extension
//           and alignment check for one data-bus access.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [ALU_OP_W-1:0]  aluop,
  input  logic [1:0]           offset,
  input  logic [DATA_W-1:0]    reg2,
  input  logic [DATA_W-1:0]    rdata,
  output logic [MEM_SEL_W-1:0] sel,
  output logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    ldata,
  output logic                 misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Offset 0 addresses the most significant lane.
  assign w_byte = rdata[{~offset, 3'b000} +: 8];
  assign w_half = offset[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    sel      = '0;
    wdata    = '0;
    ldata    = '0;
    misalign = 1'b0;
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        sel   = 4'b1000 >> offset;
        wdata = {4{reg2[7:0]}};
        ldata = (aluop == EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        sel      = offset[1] ? 4'b0011 : 4'b1100;
        wdata    = {2{reg2[15:0]}};
        ldata    = (aluop == EXE_LH_OP) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        misalign = offset[0];
      end
      EXE_LW_OP, EXE_SW_OP: begin
        sel      = 4'b1111;
        wdata    = reg2;
        ldata    = rdata;
        misalign = |offset;
      end
      default: begin
        sel = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
//------------------------------------------------------------------------------
// Module  : mem_access
// Brief   : MEM pipeline stage running req/ack data-bus loads and stores,
//           holding the pipeline until the access completes or aborts.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic [ALU_OP_W-1:0]    aluop_i,
  input  logic [DATA_ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0]  wreg_addr_i,
  input  logic                   wreg_enable_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [REG_ADDR_W-1:0]  wreg_addr_o,
  output logic                   wreg_enable_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic                   stallreq_o,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [DATA_ADDR_W-1:0] dbus_addr_o,
  output logic [MEM_SEL_W-1:0]   dbus_sel_o,
  output logic [DATA_W-1:0]      dbus_wdata_o,
  input  logic [DATA_W-1:0]      dbus_rdata_i,
  input  logic                   dbus_ack_i,
  output logic                   mem_err_o
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t             r_state;
  mem_state_t             w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_ADDR_W-1:0] r_addr;
  logic [MEM_SEL_W-1:0]   r_sel;
  logic                   r_we;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_rdata_q;
  logic                   r_abort;
  logic                   r_mem_err;

  logic                   w_is_load;
  logic                   w_is_store;
  logic                   w_start;
  logic                   w_err;
  logic                   w_stall;
  logic [MEM_SEL_W-1:0]   w_sel;
  logic [DATA_W-1:0]      w_wdata;
  logic [DATA_W-1:0]      w_ldata;
  logic                   w_misalign;

  assign w_is_load  = is_load(aluop_i);
  assign w_is_store = is_store(aluop_i);

  // Instruction inputs are held by the pipeline stall, so the aligner can
  // work straight from them during WAIT as well.
  mem_access_align u_align (
    .aluop    (aluop_i),
    .offset   (mem_addr_i[1:0]),
    .reg2     (reg2_i),
    .rdata    (dbus_rdata_i),
    .sel      (w_sel),
    .wdata    (w_wdata),
    .ldata    (w_ldata),
    .misalign (w_misalign)
  );

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_err   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_is_load || w_is_store) begin
          w_stall = 1'b1;
          if (w_misalign) begin
            w_next = MEM_DONE;
            w_err  = 1'b1;
          end else begin
            w_next  = MEM_WAIT;
            w_start = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        w_stall = 1'b1;
        // An ack on the final allowed cycle still counts as success.
        if (dbus_ack_i) begin
          w_next = MEM_DONE;
        end else if (r_cnt == c_cnt_last) begin
          w_next = MEM_DONE;
          w_err  = 1'b1;
        end
      end
      MEM_DONE: begin
        if (!stall_i) begin
          w_next = MEM_IDLE;
        end
      end
      default: begin
        w_next = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= MEM_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_rdata_q <= '0;
      r_abort   <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mem_err <= w_err;
      if (w_start) begin
        r_addr    <= {mem_addr_i[DATA_ADDR_W-1:2], 2'b00};
        r_sel     <= w_sel;
        r_we      <= w_is_store;
        r_wdata   <= w_wdata;
        r_cnt     <= '0;
        r_rdata_q <= '0;
      end else if (r_state == MEM_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (dbus_ack_i) begin
          r_rdata_q <= w_ldata;
        end
      end
      if (w_err) begin
        r_abort <= 1'b1;
      end else if ((r_state == MEM_DONE) && !stall_i) begin
        r_abort <= 1'b0;
      end
    end
  end

  always_comb begin
    wreg_addr_o   = '0;
    wreg_enable_o = 1'b0;
    wdata_o       = '0;
    stallreq_o    = 1'b0;
    dbus_req_o    = 1'b0;
    dbus_we_o     = 1'b0;
    dbus_addr_o   = '0;
    dbus_sel_o    = '0;
    dbus_wdata_o  = '0;
    mem_err_o     = 1'b0;
    if (rst) begin
      wreg_addr_o   = wreg_addr_i;
      wreg_enable_o = wreg_enable_i && !w_is_store &&
                      !(w_is_load && ((r_state != MEM_DONE) || r_abort));
      wdata_o       = (w_is_load && (r_state == MEM_DONE)) ? r_rdata_q : wdata_i;
      stallreq_o    = w_stall;
      dbus_req_o    = (r_state == MEM_WAIT);
      dbus_we_o     = r_we;
      dbus_addr_o   = r_addr;
      dbus_sel_o    = r_sel;
      dbus_wdata_o  = r_wdata;
      mem_err_o     = r_mem_err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_access
// Brief   : Self-checking bench for mem_access: directed table, corner
//           sequences and random accesses against an arithmetic model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, dbus_rdata_i;
  logic [4:0]  wreg_addr_i;
  logic        wreg_enable_i, dbus_ack_i;
  logic [4:0]  wreg_addr_o;
  logic        wreg_enable_o, stallreq_o, dbus_req_o, dbus_we_o, mem_err_o;
  logic [31:0] wdata_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_sel_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wreg_addr_i(wreg_addr_i),
    .wreg_enable_i(wreg_enable_i), .wdata_i(wdata_i), .wreg_addr_o(wreg_addr_o),
    .wreg_enable_o(wreg_enable_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i),
    .dbus_ack_i(dbus_ack_i), .mem_err_o(mem_err_o)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, reg2, wd, rd;
    int          ack_at;   // WAIT cycle carrying ack (1-based), 0 = never
    int          hold;     // extra DONE cycles with stall_i=1
    logic [3:0]  esel;
    logic [31:0] ebw, eres;
    bit          eerr;
    int          ereq;     // expected number of req cycles
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic bit m_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction
  function automatic bit m_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction
  function automatic int m_size(input logic [7:0] op);
    if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) return 1;
    if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return 2;
    return 4;
  endfunction

  function automatic vec_t model(input logic [7:0] op, input logic [31:0] addr, reg2, wd, rd,
                                 input int ack_at, input int hold);
    vec_t v;
    int sz, off;
    logic [31:0] mask, val;
    bit mis;
    v = '{op, addr, reg2, wd, rd, ack_at, hold, 4'd0, 32'd0, wd, 1'b0, 0};
    if (!(m_load(op) || m_store(op))) return v;
    sz   = m_size(op);
    off  = int'(addr % 4);
    mis  = (off % sz) != 0;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v.esel = 4'(((1 << sz) - 1) << (4 - sz - off));
    v.ebw  = (reg2 & mask) * ((sz == 1) ? 32'h0101_0101 : (sz == 2) ? 32'h0001_0001 : 32'd1);
    if (m_load(op)) begin
      val = (rd >> (8 * (4 - sz - off))) & mask;
      if ((op == EXE_LB_OP || op == EXE_LH_OP) && val[8*sz-1]) val = val | ~mask;
      v.eres = val;
    end
    v.eerr = mis || (ack_at == 0) || (ack_at > TMO);
    v.ereq = mis ? 0 : ((ack_at == 0 || ack_at > TMO) ? TMO : ack_at);
    return v;
  endfunction

  // ---------------- one instruction through the stage ----------------
  task automatic do_mem(input vec_t v, input logic [4:0] wa, input logic wen, input bit late);
    bit ld, st;
    int waits;
    logic [31:0] prev_d;
    logic        prev_e;
    ld = m_load(v.op);
    st = m_store(v.op);
    aluop_i = v.op; mem_addr_i = v.addr; reg2_i = v.reg2; wdata_i = v.wd;
    wreg_addr_i = wa; wreg_enable_i = wen; dbus_rdata_i = v.rd;
    stall_i = 1'b0; dbus_ack_i = 1'b0;
    #1;
    if (!(ld || st)) begin
      check("pass_wdata", wdata_o, v.wd);
      check("pass_wen", wreg_enable_o, wen);
      check("pass_waddr", wreg_addr_o, wa);
      check("pass_stall", stallreq_o, 0);
      @(posedge clk); #1;
      check("pass_req", dbus_req_o, 0);
      check("pass_stall2", stallreq_o, 0);
      return;
    end
    check("idle_stall", stallreq_o, 1);
    check("idle_req", dbus_req_o, 0);
    check("idle_wen", wreg_enable_o, 0);
    @(posedge clk); #1;
    waits = 0;
    while (dbus_req_o && waits < TMO + 4) begin
      dbus_ack_i = (waits + 1 == v.ack_at);
      check("wait_stall", stallreq_o, 1);
      check("wait_addr", dbus_addr_o, v.addr & 32'hFFFF_FFFC);
      check("wait_sel", dbus_sel_o, v.esel);
      check("wait_we", dbus_we_o, st);
      if (st) check("wait_bwdata", dbus_wdata_o, v.ebw);
      check("wait_wen", wreg_enable_o, 0);
      check("wait_err", mem_err_o, 0);
      waits++;
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
    end
    check("req_cycles", waits, v.ereq);
    check("done_stall", stallreq_o, 0);
    check("done_req", dbus_req_o, 0);
    check("done_err", mem_err_o, v.eerr);
    check("done_wen", wreg_enable_o, (ld && !v.eerr) ? wen : 1'b0);
    check("done_waddr", wreg_addr_o, wa);
    if (!v.eerr) check("done_wdata", wdata_o, v.eres);
    prev_d = wdata_o;
    prev_e = wreg_enable_o;
    if (v.hold > 0) begin
      stall_i = 1'b1;
      dbus_ack_i = late;
      dbus_rdata_i = 32'h5A5A_5A5A;
      repeat (v.hold) begin
        @(posedge clk); #1;
        check("hold_wdata", wdata_o, prev_d);
        check("hold_wen", wreg_enable_o, prev_e);
        check("hold_req", dbus_req_o, 0);
        check("hold_stall", stallreq_o, 0);
        check("hold_err", mem_err_o, 0);
      end
    end
    stall_i = 1'b0;
    dbus_ack_i = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[16];
  logic [7:0] ops[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          op          addr          reg2          wd            rd            ack hold esel     ebw           eres          err ereq
    tbl[0]  = '{EXE_ADD_OP, 32'h0,        32'h0,        32'h1234,     32'h0,        0,  0, 4'b0000, 32'h0,        32'h1234,     0,  0};
    tbl[1]  = '{EXE_LB_OP,  32'h1001,     32'h0,        32'h55,       32'h11F2_3344, 2, 0, 4'b0100, 32'h0,        32'hFFFF_FFF2, 0, 2};
    tbl[2]  = '{EXE_LBU_OP, 32'h1001,     32'h0,        32'h55,       32'h11F2_3344, 2, 0, 4'b0100, 32'h0,        32'h0000_00F2, 0, 2};
    tbl[3]  = '{EXE_SH_OP,  32'h2002,     32'hAAAA_BEEF, 32'h77,      32'h0,        1,  0, 4'b0011, 32'hBEEF_BEEF, 32'h77,       0,  1};
    tbl[4]  = '{EXE_LW_OP,  32'h3001,     32'h0,        32'h99,       32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        1,  0};
    tbl[5]  = '{EXE_LH_OP,  32'h1002,     32'h0,        32'h0,        32'h1234_8765, 1, 0, 4'b0011, 32'h0,        32'hFFFF_8765, 0, 1};
    tbl[6]  = '{EXE_LHU_OP, 32'h1000,     32'h0,        32'h0,        32'h8765_1234, 3, 2, 4'b1100, 32'h0,        32'h0000_8765, 0, 3};
    tbl[7]  = '{EXE_SB_OP,  32'h4003,     32'h1234_56A5, 32'h42,      32'h0,        1,  0, 4'b0001, 32'hA5A5_A5A5, 32'h42,       0,  1};
    tbl[8]  = '{EXE_SW_OP,  32'h4000,     32'hDEAD_BEEF, 32'h43,      32'h0,        2,  0, 4'b1111, 32'hDEAD_BEEF, 32'h43,       0,  2};
    tbl[9]  = '{EXE_LW_OP,  32'h5004,     32'h0,        32'h0,        32'hCAFE_F00D, 1, 2, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 1};
    tbl[10] = '{EXE_SH_OP,  32'h2001,     32'h1111_2222, 32'h44,      32'h0,        1,  0, 4'b0000, 32'h0,        32'h44,       1,  0};
    tbl[11] = '{EXE_LB_OP,  32'h0003,     32'h0,        32'h0,        32'h0000_007F, 1, 0, 4'b0001, 32'h0,        32'h0000_007F, 0, 1};
    tbl[12] = '{EXE_LW_OP,  32'h7000,     32'h0,        32'h0,        32'h0102_0304, 16, 0, 4'b1111, 32'h0,       32'h0102_0304, 0, 16};
    tbl[13] = '{EXE_LW_OP,  32'h7004,     32'h0,        32'h0,        32'h0,        0,  0, 4'b1111, 32'h0,        32'h0,        1,  16};
    tbl[14] = '{EXE_SW_OP,  32'h8000,     32'h0BAD_F00D, 32'h45,      32'h0,        0,  0, 4'b1111, 32'h0BAD_F00D, 32'h45,       1,  16};
    tbl[15] = '{EXE_LHU_OP, 32'h9003,     32'h0,        32'h0,        32'h0,        1,  0, 4'b0000, 32'h0,        32'h0,        1,  0};
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_ADD_OP};

    rst = 1'b0; stall_i = 1'b0; aluop_i = EXE_ADD_OP; mem_addr_i = '0; reg2_i = '0;
    wdata_i = 32'h1234; wreg_addr_i = 5'd3; wreg_enable_i = 1'b1;
    dbus_rdata_i = '0; dbus_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wdata", wdata_o, 0);
    check("rst_wen", wreg_enable_o, 0);
    check("rst_req", dbus_req_o, 0);
    check("rst_stall", stallreq_o, 0);
    check("rst_err", mem_err_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) do_mem(tbl[i], 5'd7, 1'b1, 1'b0);

    // Late ack after a timeout must not disturb the held result.
    do_mem(model(EXE_LW_OP, 32'hA000, 32'h0, 32'h0, 32'h0, 0, 2), 5'd9, 1'b1, 1'b1);
    do_mem(tbl[0], 5'd1, 1'b1, 1'b0);

    // Reset in the middle of WAIT, with an ack arriving during reset.
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h6000; wdata_i = 32'h77; wreg_enable_i = 1'b1;
    dbus_rdata_i = 32'h1357_9BDF;
    repeat (3) @(posedge clk);
    #1;
    check("mid_req", dbus_req_o, 1);
    rst = 1'b0;
    dbus_ack_i = 1'b1;
    #1;
    check("mrst_req", dbus_req_o, 0);
    check("mrst_stall", stallreq_o, 0);
    check("mrst_addr", dbus_addr_o, 0);
    check("mrst_sel", dbus_sel_o, 0);
    check("mrst_wdata", wdata_o, 0);
    check("mrst_waddr", wreg_addr_o, 0);
    @(posedge clk); #1;
    check("mrst_req_edge", dbus_req_o, 0);
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    rst = 1'b1;
    do_mem(model(EXE_LW_OP, 32'h6000, 32'h0, 32'h77, 32'h1357_9BDF, 1, 2), 5'd4, 1'b1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      int r, ack;
      logic [7:0] op;
      op  = ops[$urandom_range(0, 8)];
      r   = $urandom_range(0, 15);
      ack = (r == 0) ? 0 : (r == 1) ? TMO : $urandom_range(1, 4);
      do_mem(model(op, $urandom, $urandom, $urandom, $urandom, ack, $urandom_range(0, 2)),
             5'($urandom), 1'($urandom), 1'b0);
    end

    aluop_i = EXE_ADD_OP;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
